// File: rtl/regfile_dump.sv
// Register-file dump engine: walks ra from FIRST_REG to LAST_REG and streams
// (address, data) words over valid/ready, holding freeze while active.
module regfile_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  ra,
  input  logic [31:0] rd,
  output logic        freeze,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
  localparam logic [4:0] LastIdx  = 5'(LAST_REG);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e     state_q;
  logic [4:0] idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= FirstIdx;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (abort && (state_q != StIdle)) begin
      // A handshake in this same cycle still counts; nothing follows it.
      state_q   <= StIdle;
      idx_q     <= FirstIdx;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          idx_q <= FirstIdx;
          if (start) state_q <= StRead;
        end
        StRead: begin
          out_data  <= rd;
          out_addr  <= idx_q;
          out_valid <= 1'b1;
          state_q   <= StSend;
        end
        StSend: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (idx_q == LastIdx) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          idx_q   <= FirstIdx;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ra     = idx_q;
  assign freeze = (state_q != StIdle);
  assign busy   = freeze;
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table of full dumps plus hand-written
// abort, reset and single-register sequences, checked against a word queue.
module tb_regfile_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] regs [32];

  logic        start_a, abort_a, out_ready_a, freeze_a, out_valid_a, busy_a, done_a;
  logic [4:0]  ra_a, out_addr_a;
  logic [31:0] rd_a, out_data_a;

  logic        start_b, abort_b, out_ready_b, freeze_b, out_valid_b, busy_b, done_b;
  logic [4:0]  ra_b, out_addr_b;
  logic [31:0] rd_b, out_data_b;

  // Register-file model: R0 is hardwired to zero.
  assign rd_a = (ra_a == 5'd0) ? 32'd0 : regs[ra_a];
  assign rd_b = (ra_b == 5'd0) ? 32'd0 : regs[ra_b];

  regfile_dump dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .ra(ra_a), .rd(rd_a),
    .freeze(freeze_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_addr(out_addr_a), .out_data(out_data_a), .busy(busy_a), .done(done_a)
  );

  regfile_dump #(.FIRST_REG(5), .LAST_REG(5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .ra(ra_b), .rd(rd_b),
    .freeze(freeze_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_addr(out_addr_b), .out_data(out_data_b), .busy(busy_b), .done(done_b)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } word_t;

  typedef struct {
    logic [31:0] base;
    int          duty;
    int          exp_done;
    int          repulse;
  } vec_t;

  word_t exp_q[$];
  vec_t  vecs[4];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] base);
    for (int i = 0; i < 32; i++) regs[i] = base + 32'(i);
  endtask

  task automatic push_exp(input int first, input int last);
    for (int i = first; i <= last; i++)
      exp_q.push_back('{addr: 5'(i), data: (i == 0) ? 32'd0 : regs[i]});
  endtask

  task automatic accept(input logic [4:0] a, input logic [31:0] d);
    word_t w;
    chk("word expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("word addr", 32'(a), 32'(w.addr));
      chk("word data", d, w.data);
    end
  endtask

  // Full default dump on dut_a; start is driven in cycle 0.
  task automatic run_dump_a(input vec_t v);
    int done_cyc, first_fz, n_fz, n_words;
    logic held;
    logic [4:0] pa;
    logic [31:0] pd;
    preload(v.base);
    exp_q.delete();
    push_exp(0, 31);
    @(negedge clk);
    start_a = 1'b1;
    out_ready_a = 1'b0;
    done_cyc = -1; first_fz = -1; n_fz = 0; n_words = 0; held = 1'b0; pa = '0; pd = '0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      start_a = (c == v.repulse);
      if (freeze_a) begin
        n_fz++;
        if (first_fz < 0) first_fz = c;
      end
      if (held) begin
        chk("held addr", 32'(out_addr_a), 32'(pa));
        chk("held data", out_data_a, pd);
      end
      if (done_a) done_cyc = c;
      out_ready_a = (int'($urandom_range(99)) < v.duty);
      held = out_valid_a && !out_ready_a;
      pa = out_addr_a;
      pd = out_data_a;
      if (out_valid_a && out_ready_a) begin
        accept(out_addr_a, out_data_a);
        n_words++;
      end
      if (done_cyc > 0 && !freeze_a) break;
    end
    start_a = 1'b0;
    out_ready_a = 1'b0;
    chk("done seen", 32'(done_cyc > 0), 32'd1);
    chk("word count", 32'(n_words), 32'd32);
    chk("queue drained", 32'(exp_q.size()), 32'd0);
    chk("freeze first cycle", 32'(first_fz), 32'd1);
    chk("freeze length", 32'(n_fz), 32'(done_cyc));
    if (v.exp_done > 0) chk("done latency", 32'(done_cyc), 32'(v.exp_done));
  endtask

  initial begin
    int n, done_cyc, hit;
    logic [4:0] pa;
    logic [31:0] pd;
    vecs[0] = '{base: 32'h1000_0000, duty: 100, exp_done: 65, repulse: -1};
    vecs[1] = '{base: 32'h1000_0000, duty: 30,  exp_done: -1, repulse: -1};
    vecs[2] = '{base: 32'hA5A5_0000, duty: 100, exp_done: 65, repulse: 7};
    vecs[3] = '{base: 32'h0F0F_F000, duty: 60,  exp_done: -1, repulse: 20};

    reset = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; out_ready_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b0;
    preload(32'h1000_0000);
    #1;
    chk("rst out_valid", 32'(out_valid_a), 32'd0);
    chk("rst out_addr", 32'(out_addr_a), 32'd0);
    chk("rst out_data", out_data_a, 32'd0);
    chk("rst freeze", 32'(freeze_a), 32'd0);
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst done", 32'(done_a), 32'd0);
    chk("rst ra a", 32'(ra_a), 32'd0);
    chk("rst ra b", 32'(ra_b), 32'd5);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_dump_a(vecs[i]);

    // Abort while word 10 is pending with out_ready low.
    preload(32'h2000_0000);
    exp_q.delete();
    push_exp(0, 31);
    @(negedge clk);
    start_a = 1'b1;
    out_ready_a = 1'b1;
    n = 0; hit = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (out_valid_a && out_addr_a == 5'd10) begin
        out_ready_a = 1'b0;
        abort_a = 1'b1;
        hit = 1;
        break;
      end
      if (out_valid_a) begin
        accept(out_addr_a, out_data_a);
        n++;
      end
    end
    chk("abort reached word 10", 32'(hit), 32'd1);
    chk("words before abort", 32'(n), 32'd10);
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort out_valid", 32'(out_valid_a), 32'd0);
    chk("abort freeze", 32'(freeze_a), 32'd0);
    chk("abort ra", 32'(ra_a), 32'd0);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_a || out_valid_a) n++;
    end
    chk("no done after abort", 32'(n), 32'd0);
    run_dump_a('{base: 32'h2000_0000, duty: 100, exp_done: 65, repulse: -1});

    // Asynchronous reset while word 20 is on the output.
    preload(32'h3000_0000);
    exp_q.delete();
    push_exp(0, 31);
    @(negedge clk);
    start_a = 1'b1;
    out_ready_a = 1'b1;
    hit = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (out_valid_a && out_addr_a == 5'd20) begin
        hit = 1;
        break;
      end
    end
    chk("reset reached word 20", 32'(hit), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset out_valid", 32'(out_valid_a), 32'd0);
    chk("reset out_addr", 32'(out_addr_a), 32'd0);
    chk("reset out_data", out_data_a, 32'd0);
    chk("reset freeze", 32'(freeze_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset ra", 32'(ra_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready_a = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_a || out_valid_a || freeze_a) n++;
    end
    chk("idle after reset", 32'(n), 32'd0);

    // Single-register dump, ready held high.
    regs[5] = 32'hDEAD_BEEF;
    exp_q.delete();
    push_exp(5, 5);
    @(negedge clk);
    start_b = 1'b1;
    out_ready_b = 1'b1;
    n = 0; done_cyc = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin
        done_cyc = c;
        break;
      end
      if (out_valid_b) begin
        accept(out_addr_b, out_data_b);
        n++;
      end
    end
    chk("single done latency", 32'(done_cyc), 32'd3);
    chk("single word count", 32'(n), 32'd1);
    chk("single queue drained", 32'(exp_q.size()), 32'd0);

    // Single-register dump with ready held low for 50 cycles.
    exp_q.delete();
    push_exp(5, 5);
    @(negedge clk);
    start_b = 1'b1;
    out_ready_b = 1'b0;
    hit = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (out_valid_b) begin
        hit = 1;
        break;
      end
    end
    chk("stall valid seen", 32'(hit), 32'd1);
    pa = out_addr_b;
    pd = out_data_b;
    n = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!out_valid_b || out_addr_b != pa || out_data_b != pd || done_b) n++;
    end
    chk("stall hold 50 cycles", 32'(n), 32'd0);
    out_ready_b = 1'b1;
    accept(out_addr_b, out_data_b);
    done_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      out_ready_b = 1'b0;
      if (done_b) begin
        done_cyc = c;
        break;
      end
    end
    chk("stall done after accept", 32'(done_cyc), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the MIPS register file: on a start pulse it walks the register file's read port from `FIRST_REG` to `LAST_REG`, captures each 32-bit value and streams it as an (address, data) word over a valid/ready interface to a host-side consumer (UART bridge, display driver or testbench monitor). It sits beside the CPU datapath. While a dump is in progress it holds a freeze request so the core stalls and the snapshot is consistent.

## Interface
Parameters:
- `FIRST_REG`, default 0: first register index dumped; range 0..31.
- `LAST_REG`, default 31: last register index dumped; `FIRST_REG <= LAST_REG <= 31`.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  reset, asynchronous, active-high.
- `start`  input  1  begin a dump; sampled only in IDLE.
- `abort`  input  1  cancel an in-progress dump; has priority over all other inputs except `reset`.
- `ra`  output  5  read address to a combinational register-file read port.
- `rd`  input  32  read data returned for `ra` in the same cycle.
- `freeze`  output  1  stall request to the core; high in every state except IDLE.
- `out_valid`  output  1  `out_addr`/`out_data` hold a word.
- `out_ready`  input  1  consumer accepts the word when high together with `out_valid`.
- `out_addr`  output  5  register index of the current word.
- `out_data`  output  32  captured register value.
- `busy`  output  1  identical to `freeze`; provided for status readback.
- `done`  output  1  one-cycle pulse after the last word is accepted.

## Operation
- FSM states: IDLE, READ, SEND, DONE. All outputs are registered or decoded directly from state and counter. No combinational path runs from `out_ready` to any output.
- Index counter `idx` (5 bits) drives `ra` directly.
- IDLE: `idx = FIRST_REG`. If `start` is high, go to READ.
- READ: one cycle. Capture `rd` into `out_data` and `idx` into `out_addr`, set `out_valid`, go to SEND.
- SEND: hold `out_valid` and the data stable until `out_valid && out_ready`. On that handshake:
  - if `idx == LAST_REG`: clear `out_valid`, go to DONE;
  - otherwise: clear `out_valid`, `idx <= idx + 1`, go to READ.
- DONE: `done = 1` for exactly this cycle, `idx <= FIRST_REG`, go to IDLE.
- `abort` high in READ, SEND or DONE: next state IDLE, `out_valid` cleared, `idx <= FIRST_REG`, no `done` pulse. A word that is handshaked in the same cycle as `abort` counts as accepted, but no further words follow.
- `start` is ignored outside IDLE. `abort` in IDLE has no effect.
- Data is passed through unmodified. Register 0 reads as 0 from the register file and is sent as 0.
- The counter never wraps, because `LAST_REG <= 31` is the terminal compare.
- Number of words per dump is `LAST_REG - FIRST_REG + 1`. With `FIRST_REG == LAST_REG` exactly one word is sent.

## Timing
- Reset values: state IDLE, `ra = FIRST_REG`, `out_valid = 0`, `out_addr = 0`, `out_data = 0`, `freeze = 0`, `busy = 0`, `done = 0`.
- Reset asserted mid-dump returns every output to its reset value immediately. No partial word or `done` follows.
- Latencies and throughput:
  - `start` in cycle N gives `freeze = 1` from cycle N+1.
  - The first `out_valid` appears at cycle N+2.
  - With `out_ready` tied high, one word is sent every 2 cycles.
  - A full default dump (32 words) raises `done` at cycle N+65 and drops `freeze` at N+66.
- `out_addr`/`out_data` change only in the cycle after READ. They are stable throughout SEND regardless of `out_ready`.
- `ra` is stable for the whole READ cycle, so the register file's combinational read settles before capture.

## Test plan
- Preload R1..R31 with `32'h1000_0000 + i`, pulse `start`, hold `out_ready = 1` -> 32 words, addr 0..31, data 0 then `32'h1000_0001`..`32'h1000_001F`; `done` at start+65; `freeze` high exactly from start+1 to start+65.
- Same preload, `out_ready` toggling with a random ~30% duty -> identical word sequence, with no word dropped or duplicated while `out_valid` is held.
- `FIRST_REG = 5`, `LAST_REG = 5`, R5 = `32'hDEAD_BEEF` -> single word (5, `32'hDEAD_BEEF`), `done` at start+3.
- `abort` asserted while in SEND of word 10 with `out_ready = 0` -> IDLE next cycle, `out_valid = 0`, no `done`; a new `start` then dumps from address 0 again.
- `start` re-pulsed mid-dump -> ignored, sequence unchanged. `reset` pulsed at word 20 -> all outputs zero at once, `ra = FIRST_REG`.
- Single-register dump with `out_ready` held low for 50 cycles -> `out_valid` stays high and the data stays stable for the whole 50 cycles.
